// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: PC sequencing, tagged in-order responses, decode FIFO, redirect flush
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] out_q, out_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
   logic [AW-1:0] fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
   logic [AW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

   logic [31:0]   fifo_instr_q [DEPTH];
   logic [31:0]   fifo_pc_q    [DEPTH];
   logic [31:0]   tag_pc_q     [DEPTH];

   logic          resp;
   logic [CW-1:0] out_after;
   logic          credit_ok;
   logic          req_fire;
   logic          push;
   logic          pop;

   // A response with nothing outstanding is ignored so the counters cannot underflow.
   assign resp      = imem_resp_valid && (out_q != '0);
   assign out_after = out_q - CW'(resp);
   assign credit_ok = ({1'b0, out_q} + {1'b0, fifo_cnt_q}) < (CW + 1)'(DEPTH);

   assign imem_req_valid = (state_q == S_RUN) && fetch_en && !redirect_valid && credit_ok;
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign push = (state_q == S_RUN) && resp && !redirect_valid;
   assign pop  = (fifo_cnt_q != '0) && instr_ready;

   assign instr_valid = (fifo_cnt_q != '0);
   assign instr       = instr_valid ? fifo_instr_q[fifo_rd_q] : 32'h0;
   assign instr_pc    = instr_valid ? fifo_pc_q[fifo_rd_q] : 32'h0;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      out_d      = out_q;
      drop_d     = drop_q;
      fifo_cnt_d = fifo_cnt_q;
      fifo_rd_d  = fifo_rd_q;
      fifo_wr_d  = fifo_wr_q;
      tag_rd_d   = tag_rd_q;
      tag_wr_d   = tag_wr_q;
      if (redirect_valid) begin
         pc_d = redirect_pc & ~32'h3;
         if (state_q == S_IDLE) begin
            state_d = fetch_en ? S_RUN : S_IDLE;
         end else begin
            fifo_cnt_d = '0;
            fifo_rd_d  = '0;
            fifo_wr_d  = '0;
            tag_rd_d   = '0;
            tag_wr_d   = '0;
            out_d      = out_after;
            drop_d     = out_after;
            state_d    = (out_after != '0) ? S_FLUSH : S_RUN;
         end
      end else begin
         if (pop) fifo_rd_d = fifo_rd_q + AW'(1);
         if (push) begin
            fifo_wr_d = fifo_wr_q + AW'(1);
            tag_rd_d  = tag_rd_q + AW'(1);
         end
         fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
         case (state_q)
            S_IDLE: begin
               if (fetch_en) state_d = S_RUN;
            end
            S_RUN: begin
               if (req_fire) begin
                  pc_d     = pc_q + 32'd4;
                  tag_wr_d = tag_wr_q + AW'(1);
               end
               out_d = out_q + CW'(req_fire) - CW'(resp);
            end
            S_FLUSH: begin
               out_d = out_after;
               if (resp && (drop_q != '0)) drop_d = drop_q - CW'(1);
               if (drop_d == '0) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         out_q      <= '0;
         drop_q     <= '0;
         fifo_cnt_q <= '0;
         fifo_rd_q  <= '0;
         fifo_wr_q  <= '0;
         tag_rd_q   <= '0;
         tag_wr_q   <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
         fifo_cnt_q <= fifo_cnt_d;
         fifo_rd_q  <= fifo_rd_d;
         fifo_wr_q  <= fifo_wr_d;
         tag_rd_q   <= tag_rd_d;
         tag_wr_q   <= tag_wr_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and count above.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr_q[fifo_wr_q] <= imem_resp_data;
         fifo_pc_q[fifo_wr_q]    <= tag_pc_q[tag_rd_q];
      end
      if (req_fire) tag_pc_q[tag_wr_q] <= pc_q;
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch with an in-order memory model and stream scoreboard
module tb_instr_fetch;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .fetch_en        (fetch_en),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr           (instr),
      .instr_pc        (instr_pc)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          stale;
   } mreq_t;

   typedef struct {
      logic [31:0] rpc;
      logic [31:0] a0;
      logic [31:0] a1;
      logic [31:0] a2;
   } vec_t;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          lat_max = 0;
   int          fifo_n = 0;
   bit          mem_hold = 1'b0;
   bit          running = 1'b0;
   logic [31:0] exp_req_pc = RESET_PC;
   logic [31:0] exp_dec_pc = RESET_PC;
   mreq_t       mq[$];
   logic [31:0] req_log[$];
   logic [31:0] dec_log[$];
   vec_t        tbl[4];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_A5A5;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Called at a falling edge with control inputs already set; advances one clock.
   task automatic step();
      bit          rv, rdy, rsp, iv, ir, rd, fe, rs, exp_rv;
      logic [31:0] ra, rpc;
      int          stale_n, fn0;
      if (rst_n && !mem_hold && mq.size() > 0 && mq[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(mq[0].addr);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom;
      end
      #1;
      stale_n = 0;
      foreach (mq[i]) if (mq[i].stale) stale_n++;
      fn0 = fifo_n;
      if (rst_n) begin
         exp_rv = running && fetch_en && !redirect_valid && stale_n == 0 && (mq.size() + fifo_n < DEPTH);
         check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
         if (fifo_n > DEPTH) check("fifo_overflow", 32'(fifo_n), DEPTH);
         if (imem_req_valid) check("req_addr", imem_req_addr, exp_req_pc);
         check("instr_valid", 32'(instr_valid), 32'(fifo_n > 0));
         if (instr_valid && fifo_n > 0) begin
            check("instr_pc", instr_pc, exp_dec_pc);
            check("instr", instr, mem_word(exp_dec_pc));
         end
      end
      rv = imem_req_valid; rdy = imem_req_ready; ra = imem_req_addr;
      rsp = imem_resp_valid; iv = instr_valid; ir = instr_ready;
      rd = redirect_valid; rpc = redirect_pc; fe = fetch_en; rs = rst_n;
      @(posedge clk);
      cyc++;
      if (!rs) begin
         mq.delete();
         fifo_n     = 0;
         running    = 1'b0;
         exp_req_pc = RESET_PC;
         exp_dec_pc = RESET_PC;
      end else begin
         if (rsp && mq.size() > 0) begin
            if (!mq[0].stale && !rd) fifo_n++;
            void'(mq.pop_front());
         end
         if (fn0 > 0 && ir && !rd) begin
            dec_log.push_back(exp_dec_pc);
            fifo_n--;
            exp_dec_pc += 32'd4;
         end
         if (rv && rdy && !rd) begin
            req_log.push_back(ra);
            mq.push_back('{ra, cyc + $urandom_range(0, lat_max), 1'b0});
            exp_req_pc += 32'd4;
         end
         if (rd) begin
            foreach (mq[i]) mq[i].stale = 1'b1;
            fifo_n     = 0;
            exp_req_pc = rpc & ~32'h3;
            exp_dec_pc = rpc & ~32'h3;
         end
         if (fe) running = 1'b1;
      end
      if (iv && !ir && rs && !rd && fn0 > 0) check("hold_pc", instr_pc, exp_dec_pc);
      @(negedge clk);
   endtask

   task automatic check_reset_outputs();
      check("rst_req_valid", 32'(imem_req_valid), 32'h0);
      check("rst_instr_valid", 32'(instr_valid), 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
      check("rst_req_addr", imem_req_addr, RESET_PC);
   endtask

   initial begin
      tbl[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
      tbl[1] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
      tbl[2] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
      tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

      rst_n = 1'b0; fetch_en = 1'b0; imem_req_ready = 1'b0; redirect_valid = 1'b0;
      redirect_pc = 32'h0; instr_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
      @(negedge clk);
      step();
      step();
      check_reset_outputs();

      // Streaming from reset with a one-cycle memory.
      rst_n = 1'b1; fetch_en = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1; lat_max = 0;
      req_log.delete(); dec_log.delete();
      for (int t = 0; t < 60 && dec_log.size() < 3; t++) step();
      if (dec_log.size() >= 3 && req_log.size() >= 1) begin
         check("first_req", req_log[0], 32'h0);
         check("dec0", dec_log[0], 32'h0);
         check("dec1", dec_log[1], 32'h4);
         check("dec2", dec_log[2], 32'h8);
      end else check("stream_timeout", 32'(dec_log.size()), 32'd3);

      // Decode stalls: credit limit must stop requests.
      instr_ready = 1'b0;
      for (int t = 0; t < 10; t++) step();
      #1;
      check("stall_req_valid", 32'(imem_req_valid), 32'h0);
      check("stall_instr_pc", instr_pc, exp_dec_pc);
      instr_ready = 1'b1;
      for (int t = 0; t < 20; t++) step();

      // Redirect table: first three request addresses and first decoded PC.
      foreach (tbl[k]) begin
         redirect_valid = 1'b1; redirect_pc = tbl[k].rpc;
         step();
         redirect_valid = 1'b0;
         req_log.delete(); dec_log.delete();
         for (int t = 0; t < 60 && (req_log.size() < 3 || dec_log.size() < 1); t++) step();
         if (req_log.size() >= 3 && dec_log.size() >= 1) begin
            check("tbl_a0", req_log[0], tbl[k].a0);
            check("tbl_a1", req_log[1], tbl[k].a1);
            check("tbl_a2", req_log[2], tbl[k].a2);
            check("tbl_dec0", dec_log[0], tbl[k].a0);
         end else check("tbl_timeout", 32'(req_log.size()), 32'd3);
      end

      // Redirect to 0x103 with one outstanding and one buffered; k=0 response coincides.
      for (int k = 0; k < 2; k++) begin
         mem_hold = 1'b0; instr_ready = 1'b0;
         for (int t = 0; t < 40 && !(fifo_n == DEPTH && mq.size() == 0); t++) step();
         instr_ready = 1'b1;
         step();
         instr_ready = 1'b0; mem_hold = 1'b1;
         step();
         mem_hold = (k == 1);
         redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
         step();
         redirect_valid = 1'b0; mem_hold = 1'b0; instr_ready = 1'b1;
         check("redir_iv_next", 32'(instr_valid), 32'h0);
         req_log.delete(); dec_log.delete();
         for (int t = 0; t < 40 && dec_log.size() < 1; t++) step();
         if (dec_log.size() >= 1 && req_log.size() >= 1) begin
            check("redir_req0", req_log[0], 32'h0000_0100);
            check("redir_dec0", dec_log[0], 32'h0000_0100);
         end else check("redir_timeout", 32'(dec_log.size()), 32'd1);
      end

      // Reset with two requests in flight.
      mem_hold = 1'b1; instr_ready = 1'b1; fetch_en = 1'b1;
      for (int t = 0; t < 40 && !(mq.size() == 2 && fifo_n == 0); t++) step();
      check("pre_reset_outstanding", 32'(mq.size()), 32'd2);
      rst_n = 1'b0;
      step();
      check_reset_outputs();
      rst_n = 1'b1; mem_hold = 1'b0;
      req_log.delete();
      for (int t = 0; t < 20 && req_log.size() < 1; t++) step();
      if (req_log.size() >= 1) check("post_reset_req0", req_log[0], RESET_PC);
      else check("post_reset_timeout", 32'(req_log.size()), 32'd1);

      // Randomized traffic against the scoreboard.
      lat_max = 3;
      for (int t = 0; t < 3000; t++) begin
         rst_n          = ($urandom_range(0, 499) != 0);
         fetch_en       = ($urandom_range(0, 9) != 0);
         imem_req_ready = ($urandom_range(0, 9) < 7);
         instr_ready    = ($urandom_range(0, 9) < 6);
         mem_hold       = ($urandom_range(0, 3) == 0);
         redirect_valid = ($urandom_range(0, 29) == 0);
         redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
